// File: rtl/axi4_conf_if.sv
// AXI4 channel bundle between the configuration initiator and a byte-wide register target.
// Single-beat use only: no burst, size, or strobe signals are carried.
interface axi4_conf_if #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MST_ID_W     = 5,
  parameter int unsigned TRANS_RESP_W = 2
) ();
  logic [MST_ID_W-1:0]     m_awid_o;
  logic [ADDR_W-1:0]       m_awaddr_o;
  logic                    m_awvalid_o;
  logic                    m_awready_i;
  logic [DATA_W-1:0]       m_wdata_o;
  logic                    m_wvalid_o;
  logic                    m_wready_i;
  logic [TRANS_RESP_W-1:0] m_bresp_i;
  logic                    m_bvalid_i;
  logic                    m_bready_o;
  logic [MST_ID_W-1:0]     m_arid_o;
  logic [ADDR_W-1:0]       m_araddr_o;
  logic                    m_arvalid_o;
  logic                    m_arready_i;
  logic [DATA_W-1:0]       m_rdata_i;
  logic [TRANS_RESP_W-1:0] m_rresp_i;
  logic                    m_rvalid_i;
  logic                    m_rready_o;

  modport master (
    output m_awid_o, m_awaddr_o, m_awvalid_o, input m_awready_i,
    output m_wdata_o, m_wvalid_o, input m_wready_i,
    input  m_bresp_i, m_bvalid_i, output m_bready_o,
    output m_arid_o, m_araddr_o, m_arvalid_o, input m_arready_i,
    input  m_rdata_i, m_rresp_i, m_rvalid_i, output m_rready_o
  );

  modport slave (
    input  m_awid_o, m_awaddr_o, m_awvalid_o, output m_awready_i,
    input  m_wdata_o, m_wvalid_o, output m_wready_i,
    output m_bresp_i, m_bvalid_i, input m_bready_o,
    input  m_arid_o, m_araddr_o, m_arvalid_o, output m_arready_i,
    output m_rdata_i, m_rresp_i, m_rvalid_i, input m_rready_o
  );
endinterface

// File: rtl/axi4_conf_master.sv
// Single-outstanding AXI4 initiator: one request becomes one AW+W->B or AR->R transaction.
// Every bus and response output is a register; no input reaches an output combinationally.
module axi4_conf_master #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MST_ID_W     = 5,
  parameter int unsigned TRANS_RESP_W = 2,
  parameter int unsigned MST_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wr_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [DATA_W-1:0]       req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_wr_o,
  output logic [DATA_W-1:0]       rsp_rdata_o,
  output logic [TRANS_RESP_W-1:0] rsp_resp_o,
  axi4_conf_if.master             m_axi
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                  state_reg;
  logic                    req_ready_reg;
  logic                    rsp_valid_reg;
  logic                    rsp_wr_reg;
  logic [DATA_W-1:0]       rsp_rdata_reg;
  logic [TRANS_RESP_W-1:0] rsp_resp_reg;
  logic [ADDR_W-1:0]       awaddr_reg;
  logic                    awvalid_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic [ADDR_W-1:0]       araddr_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;

  // Each write channel is finished once its valid has dropped or it handshakes this cycle.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_reg || m_axi.m_awready_i;
  assign w_done  = !wvalid_reg  || m_axi.m_wready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_wr_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
      awaddr_reg    <= '0;
      awvalid_reg   <= 1'b0;
      wdata_reg     <= '0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      araddr_reg    <= '0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_reg <= 1'b0;
            if (req_wr_i) begin
              awaddr_reg  <= req_addr_i;
              awvalid_reg <= 1'b1;
              wdata_reg   <= req_wdata_i;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              araddr_reg  <= req_addr_i;
              arvalid_reg <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // Address and data are cleared once handed over so they never linger on the bus.
          if (awvalid_reg && m_axi.m_awready_i) begin
            awvalid_reg <= 1'b0;
            awaddr_reg  <= '0;
          end
          if (wvalid_reg && m_axi.m_wready_i) begin
            wvalid_reg <= 1'b0;
            wdata_reg  <= '0;
          end
          if (aw_done && w_done) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.m_bvalid_i) begin
            bready_reg    <= 1'b0;
            rsp_resp_reg  <= m_axi.m_bresp_i;
            rsp_rdata_reg <= '0;
            rsp_wr_reg    <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi.m_arready_i) begin
            arvalid_reg <= 1'b0;
            araddr_reg  <= '0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi.m_rvalid_i) begin
            rready_reg    <= 1'b0;
            rsp_resp_reg  <= m_axi.m_rresp_i;
            rsp_rdata_reg <= m_axi.m_rdata_i;
            rsp_wr_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o        = req_ready_reg;
  assign rsp_valid_o        = rsp_valid_reg;
  assign rsp_wr_o           = rsp_wr_reg;
  assign rsp_rdata_o        = rsp_rdata_reg;
  assign rsp_resp_o         = rsp_resp_reg;
  assign m_axi.m_awid_o     = MST_ID_W'(MST_ID);
  assign m_axi.m_awaddr_o   = awaddr_reg;
  assign m_axi.m_awvalid_o  = awvalid_reg;
  assign m_axi.m_wdata_o    = wdata_reg;
  assign m_axi.m_wvalid_o   = wvalid_reg;
  assign m_axi.m_bready_o   = bready_reg;
  assign m_axi.m_arid_o     = MST_ID_W'(MST_ID);
  assign m_axi.m_araddr_o   = araddr_reg;
  assign m_axi.m_arvalid_o  = arvalid_reg;
  assign m_axi.m_rready_o   = rready_reg;
endmodule

// File: tb/tb_axi4_conf_master.sv
// Bench for axi4_conf_master: directed transactions, a cycle-timeline model derived from
// per-transaction slave delays, and a per-cycle compare process on the falling edge.
module tb_axi4_conf_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_wr;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_resp;

  axi4_conf_if bus ();

  axi4_conf_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wr_o(rsp_wr),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait, rsp_wait, rst_at;
    logic [1:0]  resp;
    logic [7:0]  rdata;
    bit          junk_b;   // spurious B during a read
    bit          b2b;      // next request held valid during this one
  } txn_t;

  localparam int NT = 9;
  txn_t tv [NT];
  txn_t cur;
  int   checks = 0, errors = 0;
  int   ti = 0, k = 0, gap = 0, rst_cnt = 0;
  bit   busy = 1'b0;
  // Timeline of the active transaction, in cycles after acceptance.
  int   aw_hs, w_hs, wr_done, b_hs, ar_hs, r_hs, fin, rsp_hs;
  logic       prev_wr;
  logic [7:0] prev_rdata;
  logic [1:0] prev_resp;

  function automatic txn_t mk(bit wr, logic [31:0] a, logic [7:0] wd, int aww, int ww,
                              int arw, int bw, int rw, logic [1:0] rs, logic [7:0] rd,
                              int rspw, bit junk, bit b2b, int rst_at);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.aw_wait = aww; t.w_wait = ww; t.ar_wait = arw;
    t.b_wait = bw; t.r_wait = rw; t.resp = rs; t.rdata = rd; t.rsp_wait = rspw;
    t.junk_b = junk; t.b2b = b2b; t.rst_at = rst_at;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t txn %0d k %0d: got %h want %h", nm, $time, ti, k, act, exp);
    end
  endtask

  task automatic load_timeline();
    aw_hs   = 1 + cur.aw_wait;
    w_hs    = 1 + cur.w_wait;
    wr_done = (aw_hs > w_hs) ? aw_hs : w_hs;
    b_hs    = wr_done + 1 + cur.b_wait;
    ar_hs   = 1 + cur.ar_wait;
    r_hs    = ar_hs + 1 + cur.r_wait;
    fin     = cur.wr ? b_hs : r_hs;
    rsp_hs  = fin + 1 + cur.rsp_wait;
  endtask

  task automatic drive();
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    bus.m_awready_i = 1'b0; bus.m_wready_i = 1'b0; bus.m_bvalid_i = 1'b0; bus.m_bresp_i = '0;
    bus.m_arready_i = 1'b0; bus.m_rvalid_i = 1'b0; bus.m_rdata_i = '0; bus.m_rresp_i = '0;
    if (busy) begin
      if (k == 0) begin
        req_valid = 1'b1; req_wr = cur.wr; req_addr = cur.addr; req_wdata = cur.wdata;
      end else if (cur.b2b && ti + 1 < NT) begin
        req_valid = 1'b1; req_wr = tv[ti+1].wr; req_addr = tv[ti+1].addr;
        req_wdata = tv[ti+1].wdata;
      end
      if (cur.wr) begin
        bus.m_awready_i = (k >= aw_hs);
        bus.m_wready_i  = (k >= w_hs);
        bus.m_bvalid_i  = (k == b_hs);
        bus.m_bresp_i   = (k == b_hs) ? cur.resp : 2'b00;
      end else begin
        bus.m_arready_i = (k >= ar_hs);
        bus.m_rvalid_i  = (k == r_hs);
        bus.m_rdata_i   = (k == r_hs) ? cur.rdata : 8'h00;
        bus.m_rresp_i   = (k == r_hs) ? cur.resp : 2'b00;
        if (cur.junk_b) begin
          bus.m_bvalid_i = 1'b1;
          bus.m_bresp_i  = 2'b11;
        end
      end
      rsp_ready = (k >= rsp_hs);
    end
  endtask

  // Per-cycle comparison of every output against the timeline model, plus pinned literals.
  always @(negedge clk) begin
    bit e_awv, e_wv, e_bre, e_arv, e_rre, e_rsv, e_rqr;
    e_awv = busy && cur.wr  && k >= 1 && k <= aw_hs;
    e_wv  = busy && cur.wr  && k >= 1 && k <= w_hs;
    e_bre = busy && cur.wr  && k > wr_done && k <= b_hs;
    e_arv = busy && !cur.wr && k >= 1 && k <= ar_hs;
    e_rre = busy && !cur.wr && k > ar_hs && k <= r_hs;
    e_rsv = busy && k > fin && k <= rsp_hs;
    e_rqr = !busy || k == 0;
    chk("req_ready", req_ready, e_rqr);
    chk("awvalid", bus.m_awvalid_o, e_awv);
    chk("awaddr", bus.m_awaddr_o, e_awv ? cur.addr : 32'h0);
    chk("wvalid", bus.m_wvalid_o, e_wv);
    chk("wdata", bus.m_wdata_o, e_wv ? cur.wdata : 8'h0);
    chk("bready", bus.m_bready_o, e_bre);
    chk("arvalid", bus.m_arvalid_o, e_arv);
    chk("araddr", bus.m_araddr_o, e_arv ? cur.addr : 32'h0);
    chk("rready", bus.m_rready_o, e_rre);
    chk("awid", bus.m_awid_o, 32'h0);
    chk("arid", bus.m_arid_o, 32'h0);
    chk("rsp_valid", rsp_valid, e_rsv);
    chk("rsp_wr", rsp_wr, prev_wr);
    chk("rsp_rdata", rsp_rdata, prev_rdata);
    chk("rsp_resp", rsp_resp, prev_resp);
    if (busy) begin
      case (ti)
        0: begin
          if (k == 1) begin chk("t0_awaddr", bus.m_awaddr_o, 32'h3000_0003);
                            chk("t0_wdata", bus.m_wdata_o, 32'h2A); end
          if (k == 2) begin chk("t0_aw_one_cycle", bus.m_awvalid_o, 0);
                            chk("t0_bready", bus.m_bready_o, 1); end
          if (k == 3) begin chk("t0_rsp_valid", rsp_valid, 1); chk("t0_rsp_wr", rsp_wr, 1);
                            chk("t0_rsp_resp", rsp_resp, 0); end
        end
        1: begin
          if (k == 2) chk("t1_w_dropped", bus.m_wvalid_o, 0);
          if (k >= 2 && k <= 4) chk("t1_awaddr_stable", bus.m_awaddr_o, 32'h3000_0010);
          if (k == 4) begin chk("t1_awvalid_c4", bus.m_awvalid_o, 1);
                            chk("t1_bready_c4", bus.m_bready_o, 0); end
          if (k == 5) chk("t1_bready_c5", bus.m_bready_o, 1);
        end
        2: if (k == 5) begin chk("t2_rdata", rsp_rdata, 32'h5C); chk("t2_resp", rsp_resp, 0);
                             chk("t2_wr", rsp_wr, 0); chk("t2_valid", rsp_valid, 1); end
        3: if (k == 3) begin chk("t3_resp", rsp_resp, 32'h3); chk("t3_rdata", rsp_rdata, 0); end
        4: if (k == 7) begin chk("t4_req_ready", req_ready, 0); chk("t4_rsp_valid", rsp_valid, 1);
                             chk("t4_rdata", rsp_rdata, 32'hA5); end
        5: begin
          if (k == 0) chk("t5_accept_ready", req_ready, 1);
          if (k == 1) chk("t5_awaddr", bus.m_awaddr_o, 32'h3000_0002);
        end
        7: if (k == 3) begin chk("t7_rsp_valid", rsp_valid, 1); chk("t7_rsp_wr", rsp_wr, 1); end
        8: if (k == 6) begin chk("t8_rdata", rsp_rdata, 32'hEE); chk("t8_resp", rsp_resp, 32'h3); end
        default: ;
      endcase
    end
  end

  initial begin
    //          wr  addr           wd    aw w ar b r  resp   rdata  rspw junk b2b rst
    tv[0] = mk(1, 32'h3000_0003, 8'h2A, 0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0);
    tv[1] = mk(1, 32'h3000_0010, 8'h11, 3, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0);
    tv[2] = mk(0, 32'h3000_0006, 8'h00, 0, 0, 0, 0, 2, 2'b00, 8'h5C, 0, 1, 0, 0);
    tv[3] = mk(1, 32'h3000_0020, 8'h77, 0, 0, 0, 0, 0, 2'b11, 8'h00, 0, 0, 0, 0);
    tv[4] = mk(0, 32'h3000_0001, 8'h00, 0, 0, 0, 0, 0, 2'b00, 8'hA5, 5, 0, 1, 0);
    tv[5] = mk(1, 32'h3000_0002, 8'h3C, 0, 2, 0, 1, 0, 2'b00, 8'h00, 1, 0, 0, 0);
    tv[6] = mk(1, 32'h3000_0004, 8'h99, 0, 0, 0, 4, 0, 2'b00, 8'h00, 0, 0, 0, 3);
    tv[7] = mk(1, 32'h3000_0005, 8'h42, 0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 0, 0, 0);
    tv[8] = mk(0, 32'h3000_0030, 8'h00, 0, 0, 2, 0, 1, 2'b11, 8'hEE, 0, 0, 0, 0);
    prev_wr = 1'b0; prev_rdata = '0; prev_resp = '0;
    cur = tv[0];
    load_timeline();
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    gap = 1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
      end
      if (busy) begin
        k++;
        if (k == fin + 1) begin
          prev_wr = cur.wr; prev_rdata = cur.wr ? 8'h00 : cur.rdata; prev_resp = cur.resp;
        end
        if (k > rsp_hs) begin
          $display("txn %0d %s addr=%h resp=%b rdata=%h complete", ti, cur.wr ? "WR" : "RD",
                   cur.addr, prev_resp, prev_rdata);
          busy = 1'b0; gap = cur.b2b ? 0 : 2; ti++;
        end
      end
      if (!busy && rst_n && gap == 0 && ti < NT) begin
        cur = tv[ti]; load_timeline(); k = 0; busy = 1'b1;
      end else if (!busy && gap > 0) begin
        gap--;
      end
      if (busy && cur.rst_at != 0 && k == cur.rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_awvalid", bus.m_awvalid_o, 0); chk("rst_wvalid", bus.m_wvalid_o, 0);
        chk("rst_bready", bus.m_bready_o, 0);   chk("rst_arvalid", bus.m_arvalid_o, 0);
        chk("rst_rready", bus.m_rready_o, 0);   chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        $display("txn %0d %s addr=%h abandoned by reset", ti, cur.wr ? "WR" : "RD", cur.addr);
        busy = 1'b0; prev_wr = 1'b0; prev_rdata = '0; prev_resp = '0;
        ti++; rst_cnt = 2; gap = 2;
      end
      drive();
      if (ti >= NT && !busy) break;
    end
    if (ti < NT) chk("all_txns_run", ti, NT);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
